modsq_result_reduce: RTL and testbench



---
 rtl/vdfpackage.sv | 12 +
 rtl/modsq_result_reduce_if.sv | 20 ++
 rtl/modsq_result_reduce_limb_sub_borrow.sv | 15 +
 rtl/modsq_result_reduce.sv | 104 ++++++++++
 tb/tb_modsq_result_reduce.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/vdfpackage.sv
// vdfpackage: shared VDF constants, state encoding, limb type and the
// big-integer reference reduction used by the bench.
package vdfpackage;
    localparam int MOD_LEN = 1024;
    localparam int LIMB_W = 64;
    localparam logic [MOD_LEN-1:0] MODULUS_DEF = {16{64'hC3A5_5A3C_F00F_0FF1}};
    typedef logic [LIMB_W-1:0] limb_t;
    typedef enum logic [1:0] {IDLE, COUNT, SUB, DONE} state_t;
    function automatic logic [MOD_LEN-1:0] bigmod(input logic [MOD_LEN-1:0] x, input logic [MOD_LEN-1:0] m);
        return x % m;
    endfunction
endpackage

// File: rtl/modsq_result_reduce_if.sv
// modsq_result_reduce_if: squarer stream in, iteration control and canonical
// result handshake out.
interface modsq_result_reduce_if #(
    parameter int MOD_LEN = 1024,
    parameter int CNT_W = 64
);
    logic start;
    logic [CNT_W-1:0] iter_target;
    logic sq_valid;
    logic [MOD_LEN-1:0] sq_out;
    logic busy;
    logic [CNT_W-1:0] iter_count;
    logic [MOD_LEN-1:0] result;
    logic result_valid;
    logic result_ready;
    modport master(output start, iter_target, sq_valid, sq_out, result_ready,
                   input busy, iter_count, result, result_valid);
    modport slave(input start, iter_target, sq_valid, sq_out, result_ready,
                  output busy, iter_count, result, result_valid);
endinterface

// File: rtl/modsq_result_reduce_limb_sub_borrow.sv
// limb_sub_borrow: combinational W-bit subtract a - b - bin with borrow out.
module limb_sub_borrow #(
    parameter int W = 64
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         bin,
    output logic [W-1:0] d,
    output logic         bout
);
    logic [W:0] diff;
    assign diff = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
    assign d = diff[W-1:0];
    assign bout = diff[W];
endmodule

// File: rtl/modsq_result_reduce.sv
// modsq_result_reduce: counts squarings to a target, captures sq_out and reduces
// it from [0, 2^MOD_LEN) into [0, M) with one limb-serial conditional subtract.
module modsq_result_reduce #(
    parameter int MOD_LEN = vdfpackage::MOD_LEN,
    parameter int LIMB_W = vdfpackage::LIMB_W,
    parameter int CNT_W = 64,
    parameter logic [MOD_LEN-1:0] MODULUS = vdfpackage::MODULUS_DEF
) (
    input logic clk,
    input logic reset,
    modsq_result_reduce_if.slave bus
);
    import vdfpackage::*;
    localparam int NLIMB = MOD_LEN / LIMB_W;
    localparam int IW = (NLIMB > 1) ? $clog2(NLIMB) : 1;
    state_t state_q, state_d;
    logic [CNT_W-1:0] target_q, target_d, cnt_q, cnt_d;
    logic [MOD_LEN-1:0] x_q, x_d, d_q, d_d, res_q, res_d, m_sh;
    logic rv_q, rv_d, bor_q, bor_d, b_out;
    logic [IW-1:0] idx_q, idx_d;
    logic [LIMB_W-1:0] d_k;
    // x rotates right one limb per SUB cycle, so its LSB limb is always the live one
    assign m_sh = MODULUS >> (LIMB_W * int'(idx_q));
    limb_sub_borrow #(.W(LIMB_W)) u_sub (
        .a(x_q[LIMB_W-1:0]),
        .b(m_sh[LIMB_W-1:0]),
        .bin(bor_q),
        .d(d_k),
        .bout(b_out)
    );
    always_comb begin
        state_d = state_q;
        target_d = target_q;
        cnt_d = cnt_q;
        x_d = x_q;
        d_d = d_q;
        res_d = res_q;
        rv_d = rv_q;
        bor_d = bor_q;
        idx_d = idx_q;
        if (bus.start) begin
            state_d = COUNT;
            target_d = (bus.iter_target == '0) ? CNT_W'(1) : bus.iter_target;
            cnt_d = '0;
            rv_d = 1'b0;
        end else begin
            case (state_q)
                COUNT: if (bus.sq_valid) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_d == target_q) begin
                        x_d = bus.sq_out;
                        bor_d = 1'b0;
                        idx_d = '0;
                        state_d = SUB;
                    end
                end
                SUB: begin
                    x_d = {x_q[LIMB_W-1:0], x_q[MOD_LEN-1:LIMB_W]};
                    d_d = {d_k, d_q[MOD_LEN-1:LIMB_W]};
                    bor_d = b_out;
                    idx_d = idx_q + IW'(1);
                    // final borrow set means x < M, so x is already canonical
                    if (idx_q == IW'(NLIMB - 1)) begin
                        res_d = b_out ? x_d : d_d;
                        rv_d = 1'b1;
                        state_d = DONE;
                    end
                end
                DONE: if (bus.result_ready) begin
                    rv_d = 1'b0;
                    state_d = IDLE;
                end
                default: ;
            endcase
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            target_q <= '0;
            cnt_q <= '0;
            x_q <= '0;
            d_q <= '0;
            res_q <= '0;
            rv_q <= 1'b0;
            bor_q <= 1'b0;
            idx_q <= '0;
        end else begin
            state_q <= state_d;
            target_q <= target_d;
            cnt_q <= cnt_d;
            x_q <= x_d;
            d_q <= d_d;
            res_q <= res_d;
            rv_q <= rv_d;
            bor_q <= bor_d;
            idx_q <= idx_d;
        end
    end
    assign bus.busy = (state_q == COUNT) || (state_q == SUB);
    assign bus.iter_count = cnt_q;
    assign bus.result = res_q;
    assign bus.result_valid = rv_q;
endmodule

// File: tb/tb_modsq_result_reduce.sv
// tb_modsq_result_reduce: transaction-level model with per-cycle compare plus
// directed scenarios pinned by hand-derived expectations.
module tb_modsq_result_reduce;
    import vdfpackage::*;
    localparam int W = MOD_LEN;
    localparam logic [W-1:0] M = MODULUS_DEF;
    localparam logic [W-1:0] ONES = '1;
    localparam logic [W-1:0] PAT = {16{64'h1234_5678_9abc_def0}};
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;
    modsq_result_reduce_if #(.MOD_LEN(W), .CNT_W(64)) bus ();
    modsq_result_reduce dut (.clk(clk), .reset(reset), .bus(bus));
    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    bit armed = 1'b0;
    logic m_counting = 1'b0;
    int m_wait = 0;
    logic m_valid = 1'b0;
    logic [W-1:0] m_res = '0;
    logic [W-1:0] m_pend = '0;
    logic [63:0] m_cnt = '0;
    logic [63:0] m_tgt = '0;
    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %h..%h want %h..%h", name, cyc,
                     act[W-1:W-64], act[63:0], exp[W-1:W-64], exp[63:0]);
        end
    endtask
    // model: job = count valids to target, then the reduced value appears 16 cycles later
    always @(posedge clk) begin
        cyc++;
        armed = 1'b1;
        if (reset) begin
            m_counting = 1'b0;
            m_wait = 0;
            m_valid = 1'b0;
            m_res = '0;
            m_cnt = '0;
        end else if (bus.start) begin
            m_counting = 1'b1;
            m_wait = 0;
            m_valid = 1'b0;
            m_cnt = '0;
            m_tgt = (bus.iter_target == 0) ? 64'd1 : bus.iter_target;
        end else if (m_counting && bus.sq_valid) begin
            m_cnt++;
            if (m_cnt == m_tgt) begin
                m_counting = 1'b0;
                m_pend = bigmod(bus.sq_out, M);
                m_wait = 16;
            end
        end else if (m_wait > 0) begin
            m_wait--;
            if (m_wait == 0) begin
                m_valid = 1'b1;
                m_res = m_pend;
            end
        end else if (m_valid && bus.result_ready) begin
            m_valid = 1'b0;
        end
    end
    always @(negedge clk) begin
        if (armed) begin
            chk("busy", W'(bus.busy), W'(m_counting || m_wait > 0));
            chk("result_valid", W'(bus.result_valid), W'(m_valid));
            chk("iter_count", W'(bus.iter_count), W'(m_cnt));
            chk("result", bus.result, m_res);
        end
    end
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic start_job(input logic [63:0] t);
        bus.start = 1'b1;
        bus.iter_target = t;
        tick();
        bus.start = 1'b0;
    endtask
    task automatic sq(input logic [W-1:0] v);
        bus.sq_valid = 1'b1;
        bus.sq_out = v;
        tick();
        bus.sq_valid = 1'b0;
    endtask
    task automatic wait_valid(output int at);
        at = -1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.result_valid) begin
                at = cyc;
                break;
            end
        end
        n_cmp++;
        if (at < 0) begin
            n_bad++;
            $display("FAIL wait_valid: result_valid still 0 after 40 cycles, want 1");
        end
    endtask
    task automatic release_result();
        bus.result_ready = 1'b1;
        tick();
        bus.result_ready = 1'b0;
        chk("release_valid", W'(bus.result_valid), '0);
        chk("release_busy", W'(bus.busy), '0);
    endtask
    initial begin
        int cap;
        int rise;
        bus.start = 1'b0;
        bus.iter_target = '0;
        bus.sq_valid = 1'b0;
        bus.sq_out = '0;
        bus.result_ready = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        chk("reset_busy", W'(bus.busy), '0);
        chk("reset_valid", W'(bus.result_valid), '0);
        chk("reset_result", bus.result, '0);
        chk("reset_count", W'(bus.iter_count), '0);
        chk("model_bigmod_m", bigmod(M, M), '0);
        chk("model_bigmod_ones", bigmod(ONES, M), ~M);
        chk("model_bigmod_pat", bigmod(PAT, M), PAT);
        // pass-through of M-1 and the 16-cycle latency
        start_job(64'd1);
        sq(M - W'(1));
        cap = cyc;
        wait_valid(rise);
        chk("latency", W'(rise - cap), W'(16));
        chk("pass_result", bus.result, M - W'(1));
        chk("pass_count", W'(bus.iter_count), W'(1));
        release_result();
        // exact modulus
        start_job(64'd1);
        sq(M);
        wait_valid(rise);
        chk("exact_m", bus.result, '0);
        release_result();
        // all-ones input
        start_job(64'd1);
        sq(ONES);
        wait_valid(rise);
        chk("max_input", bus.result, ~M);
        release_result();
        // T=3: third pulse captured, fourth (during SUB) ignored
        start_job(64'd3);
        for (int i = 1; i <= 16; i++) begin
            bus.sq_valid = (i == 5 || i == 9 || i == 13 || i == 15);
            bus.sq_out = (i == 13) ? PAT : ONES;
            tick();
        end
        bus.sq_valid = 1'b0;
        chk("count3_busy_count", W'(bus.iter_count), W'(3));
        wait_valid(rise);
        chk("count3_result", bus.result, PAT);
        chk("count3_count", W'(bus.iter_count), W'(3));
        release_result();
        // T=0 clamped to 1, then backpressure
        start_job(64'd0);
        sq(ONES);
        wait_valid(rise);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("hold_valid", W'(bus.result_valid), W'(1));
            chk("hold_result", bus.result, ~M);
        end
        release_result();
        // abort during limb 7, then a fresh job counting from 0
        start_job(64'd1);
        sq(M + W'(5));
        repeat (7) tick();
        start_job(64'd2);
        chk("abort_count", W'(bus.iter_count), '0);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("abort_no_valid", W'(bus.result_valid), '0);
        end
        sq(W'(1));
        chk("abort_recount", W'(bus.iter_count), W'(1));
        sq(M + W'(7));
        wait_valid(rise);
        chk("abort_result", bus.result, W'(7));
        chk("abort_final_count", W'(bus.iter_count), W'(2));
        // reset while DONE
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("done_reset_valid", W'(bus.result_valid), '0);
        chk("done_reset_result", bus.result, '0);
        chk("done_reset_busy", W'(bus.busy), '0);
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
